// File: rtl/icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icg_enable_ctrl
//  Purpose  : Idle-detecting enable controller for a negative-edge ICG.
//             Drives the gate's E/TE inputs and a RDY handshake telling the
//             gated domain when its clock is stable after wake-up.
//  Options  : define ICG_ENABLE_CTRL_STATS_EN to add the GATED_CNT
//             saturating counter of closed-gate cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              FORCE_ON,
  input  logic              SE,
  output logic              E,
  output logic              TE,
  output logic              RDY,
`ifdef ICG_ENABLE_CTRL_STATS_EN
  output logic              GATED,
  output logic [STAT_W-1:0] GATED_CNT
`else
  output logic              GATED
`endif
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  // Terminal counts: each counter is cleared on the transition it triggers,
  // so it never has to wrap.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  // Reject out-of-range configurations at elaboration.
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
    $error("icg_enable_ctrl: IDLE_CYCLES must be 1..255");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("icg_enable_ctrl: WAKE_CYCLES must be 1..255");
  end
  if (STAT_W < 1) begin : g_bad_stat
    $error("icg_enable_ctrl: STAT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_WAKE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GATED = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic               e_q,        e_d;
  logic               rdy_q,      rdy_d;
  logic               gated_q,    gated_d;
  logic               activity;

  assign activity = REQ | FORCE_ON;

  // Next-state logic; outputs are decoded from the next state so that the
  // registered E/RDY/GATED change on the same edge as the state itself.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    case (state_q)
      ST_WAKE: begin
        // Requests are ignored while the clock is re-stabilising.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      ST_RUN: begin
        // Activity on the final idle cycle wins over gating.
        if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        if (activity) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_WAKE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    e_d     = (state_d != ST_GATED);
    rdy_d   = (state_d == ST_RUN);
    gated_d = (state_d == ST_GATED);
  end

  // State, counters and registered gate controls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_WAKE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      e_q        <= 1'b1;
      rdy_q      <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      e_q        <= e_d;
      rdy_q      <= rdy_d;
      gated_q    <= gated_d;
    end
  end

  assign E     = e_q;
  assign RDY   = rdy_q;
  assign GATED = gated_q;

  // Test enable bypasses the FSM entirely so scan shifts see every pulse.
  assign TE = SE;

`ifdef ICG_ENABLE_CTRL_STATS_EN
  logic [STAT_W-1:0] gated_cnt_q, gated_cnt_d;

  // Saturating count of edges seen with the gate closed.
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (gated_q && (gated_cnt_q != {STAT_W{1'b1}})) begin
      gated_cnt_d = gated_cnt_q + STAT_W'(1);
    end
  end

  // Statistics register, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gated_cnt_q <= '0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign GATED_CNT = gated_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icg_enable_ctrl
//  Purpose  : Self-checking bench for icg_enable_ctrl (IDLE=4, WAKE=2,
//             STAT_W=4) using a timestamp-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icg_enable_ctrl;

  localparam int IDLE  = 4;
  localparam int WAKE  = 2;
  localparam int SW    = 4;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          force_on = 1'b0;
  logic          se = 1'b0;
  logic          e, te, rdy, gated;
  logic [SW-1:0] gated_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: edge timestamps and an idle streak length.
  int m_edge;
  int m_wake_edge;
  int m_idle;
  bit m_gated;
  int m_cnt;

  always #5 clk = ~clk;

  icg_enable_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .STAT_W     (SW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .FORCE_ON (force_on),
    .SE       (se),
    .E        (e),
    .TE       (te),
    .RDY      (rdy),
`ifdef ICG_ENABLE_CTRL_STATS_EN
    .GATED    (gated),
    .GATED_CNT(gated_cnt)
`else
    .GATED    (gated)
`endif
  );

`ifndef ICG_ENABLE_CTRL_STATS_EN
  assign gated_cnt = '0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edge      = 0;
    m_wake_edge = 0;
    m_idle      = 0;
    m_gated     = 1'b0;
    m_cnt       = 0;
  endtask

  // One rising edge with the given activity sampled.
  task automatic model_step(input bit act);
    m_edge++;
    if (m_gated && m_cnt < SMAX) m_cnt++;
    if (m_gated) begin
      if (act) begin
        m_gated     = 1'b0;
        m_wake_edge = m_edge;
        m_idle      = 0;
      end
    end else if ((m_edge - 1 - m_wake_edge) >= WAKE) begin
      if (act) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == IDLE) begin
          m_gated = 1'b1;
          m_idle  = 0;
        end
      end
    end
  endtask

  function automatic int exp_e();
    return m_gated ? 0 : 1;
  endfunction

  function automatic int exp_rdy();
    return (!m_gated && (m_edge - m_wake_edge) >= WAKE) ? 1 : 0;
  endfunction

  // Drive inputs after the edge, advance one edge, update the model.
  task automatic cyc(input bit r, input bit f, input bit s);
    req      = r;
    force_on = f;
    se       = s;
    @(posedge clk);
    if (!rst) model_step(req | force_on);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("E", int'(e), exp_e());
    check("RDY", int'(rdy), exp_rdy());
    check("GATED", int'(gated), m_gated ? 1 : 0);
    check("TE", int'(te), int'(se));
`ifdef ICG_ENABLE_CTRL_STATS_EN
    check("GATED_CNT", int'(gated_cnt), m_cnt);
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int thr;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_E", int'(e), 1);
    check("reset_RDY", int'(rdy), 0);
    rst = 1'b0;

    // Wake-up after reset: RDY after exactly two edges.
    cyc(0, 0, 0);
    check("wake1_RDY", int'(rdy), 0);
    cyc(0, 0, 0);
    check("wake2_RDY", int'(rdy), 1);

    // Gate-off: last REQ then four idle edges.
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    check("idle3_E", int'(e), 1);
    cyc(0, 0, 0);
    check("idle4_E", int'(e), 0);
    check("idle4_GATED", int'(gated), 1);
    check("idle4_RDY", int'(rdy), 0);

    // Wake handshake with REQ dropped during WAKE.
    cyc(1, 0, 0);
    check("wk_E", int'(e), 1);
    check("wk_RDY0", int'(rdy), 0);
    cyc(0, 0, 0);
    check("wk_RDY1", int'(rdy), 0);
    cyc(0, 0, 0);
    check("wk_RDY2", int'(rdy), 1);

    // Race: REQ on the final idle cycle keeps RUN and restarts the count.
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("race_E", int'(e), 1);
    repeat (3) cyc(0, 0, 0);
    check("race_restart_E", int'(e), 1);
    cyc(0, 0, 0);
    check("race_gate_GATED", int'(gated), 1);

    // Scan enable while gated.
    se = 1'b1;
    #1;
    check("scan_TE", int'(te), 1);
    cyc(0, 0, 1);
    check("scan_GATED", int'(gated), 1);
    cyc(0, 0, 0);

    // FORCE_ON override for 100 cycles.
    repeat (100) cyc(0, 1, 0);
    check("force_E", int'(e), 1);
    check("force_RDY", int'(rdy), 1);
    repeat (4) cyc(0, 0, 0);
    check("force_off_GATED", int'(gated), 1);

    // Mid-wake asynchronous reset.
    cyc(1, 0, 0);
    pulse_reset();
    check("midrst_E", int'(e), 1);
    check("midrst_RDY", int'(rdy), 0);
    check("midrst_GATED", int'(gated), 0);
    #2;
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("midrst_wake_RDY", int'(rdy), 1);

`ifdef ICG_ENABLE_CTRL_STATS_EN
    repeat (IDLE) cyc(0, 0, 0);
    repeat (20) cyc(0, 0, 0);
    check("stat_sat", int'(gated_cnt), 15);
    pulse_reset();
    check("stat_clr", int'(gated_cnt), 0);
    #2;
    rst = 1'b0;
`endif

    // Randomised traffic with varying request density and rare resets.
    thr = 20;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       thr = 3;
          1:       thr = 20;
          default: thr = 60;
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
        #2;
        rst = 1'b0;
      end
      cyc($urandom_range(0, 99) < thr, $urandom_range(0, 63) == 0,
          $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
